// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter: RAM geometry and the
// host-port FSM state encoding.
package mem_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the MEM stage (always wins) and a host port
// that completes its single outstanding access in the first CPU-idle cycle.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int XFER_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DMEM_ADDR_W-1:0] cpu_addr,
  input  logic [DMEM_DATA_W-1:0] cpu_wdata,
  input  logic                   cpu_MemRead,
  input  logic                   cpu_MemWrite,
  output logic [DMEM_DATA_W-1:0] cpu_rdata,
  input  logic                   host_valid,
  input  logic                   host_we,
  input  logic [DMEM_ADDR_W-1:0] host_addr,
  input  logic [DMEM_DATA_W-1:0] host_wdata,
  output logic                   host_ready,
  output logic                   host_done,
  output logic [DMEM_DATA_W-1:0] host_rdata,
  output logic [DMEM_ADDR_W-1:0] ram_addr,
  output logic [DMEM_DATA_W-1:0] ram_wdata,
  output logic                   ram_MemRead,
  output logic                   ram_MemWrite,
  input  logic [DMEM_DATA_W-1:0] ram_rdata,
  output logic                   starve,
  output logic [XFER_W-1:0]      host_xfers,
  output logic [1:0]             dbg_state
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // Handshake: a request transfers on any cycle where host_valid & host_ready;
  // host_we/addr/wdata are sampled only then, and host_done pulses once per request.
  arb_state_e state_q, state_d;
  logic                   we_q, we_d;
  logic [DMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [DMEM_DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   cpu_busy;
  logic                   accept;

  assign cpu_busy   = cpu_MemRead | cpu_MemWrite;
  assign host_ready = (state_q == IDLE) | (state_q == DONE);
  assign accept     = host_valid & host_ready;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    host_rdata_d = host_rdata_q;
    if (accept) begin
      we_d    = host_we;
      addr_d  = host_addr;
      wdata_d = host_wdata;
    end
    case (state_q)
      IDLE: if (accept) state_d = PEND;
      PEND: begin
        if (!cpu_busy) begin
          state_d = DONE;
          if (!we_q) host_rdata_d = ram_rdata;
        end
      end
      DONE:    state_d = accept ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_q == PEND) & cpu_busy),
    .clr   (accept),
    .cnt   (wait_cnt)
  );

  sat_counter #(.W(XFER_W), .MAX({XFER_W{1'b1}})) u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == DONE),
    .clr   (1'b0),
    .cnt   (host_xfers)
  );

  // Held host request reaches the RAM only while PEND and the CPU is idle;
  // reset forces IDLE asynchronously, so a pending write vanishes at once.
  always_comb begin
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_MemRead  = 1'b0;
    ram_MemWrite = 1'b0;
    if (cpu_busy) begin
      ram_addr     = cpu_addr;
      ram_wdata    = cpu_wdata;
      ram_MemRead  = cpu_MemRead;
      ram_MemWrite = cpu_MemWrite;
    end else if (state_q == PEND) begin
      ram_addr     = addr_q;
      ram_wdata    = wdata_q;
      ram_MemRead  = ~we_q;
      ram_MemWrite = we_q;
    end
  end

  assign cpu_rdata  = ram_rdata;
  assign host_done  = (state_q == DONE);
  assign host_rdata = host_rdata_q;
  assign starve     = (state_q == PEND) & (wait_cnt >= WAIT_MAX);
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-byte RAM model.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_MemRead, cpu_MemWrite;
  logic       host_valid, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_ready, host_done;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_MemRead, ram_MemWrite;
  logic       starve;
  logic [3:0] host_xfers;
  logic [1:0] dbg_state;

  logic [7:0] mem [256];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_x;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_MemWrite) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  dmem_arbiter #(.MAX_WAIT(15), .XFER_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite), .cpu_rdata(cpu_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_done(host_done),
    .host_rdata(host_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_MemRead(ram_MemRead), .ram_MemWrite(ram_MemWrite), .ram_rdata(ram_rdata),
    .starve(starve), .host_xfers(host_xfers), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic we, input logic [7:0] a, input logic [7:0] d);
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(host_ready), 32'd1);
    chk({tag, "_done"},  32'(host_done),  32'd0);
    chk({tag, "_rdata"}, 32'(host_rdata), 32'h0);
    chk({tag, "_xfers"}, 32'(host_xfers), 32'd0);
    chk({tag, "_starve"}, 32'(starve),    32'd0);
    chk({tag, "_state"}, 32'(dbg_state),  32'd0);
    chk({tag, "_ramwe"}, 32'(ram_MemWrite), 32'd0);
    chk({tag, "_ramre"}, 32'(ram_MemRead),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h30] = 8'h11;
    mem[8'h50] = 8'h99;
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #1;
    chk_reset_vals("rst");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Idle CPU: write 0x10=A5, then read it back from DONE
    host_req(1'b1, 8'h10, 8'hA5);
    tick();
    host_valid = 1'b0;
    chk("w_pend_ready", 32'(host_ready), 32'd0);
    chk("w_ram_we",     32'(ram_MemWrite), 32'd1);
    chk("w_ram_addr",   32'(ram_addr), 32'h10);
    chk("w_ram_wdata",  32'(ram_wdata), 32'hA5);
    tick();
    chk("w_done",  32'(host_done), 32'd1);
    chk("w_mem",   32'(mem[8'h10]), 32'hA5);
    host_req(1'b0, 8'h10, 8'h00);
    tick();
    host_valid = 1'b0;
    chk("r_xfers1", 32'(host_xfers), 32'd1);
    chk("r_ram_re", 32'(ram_MemRead), 32'd1);
    tick();
    chk("r_done",  32'(host_done), 32'd1);
    chk("r_rdata", 32'(host_rdata), 32'hA5);
    tick();
    chk("r_idle_done", 32'(host_done), 32'd0);
    chk("r_xfers2",    32'(host_xfers), 32'd2);

    // CPU stores 0x20 for 20 cycles while the host reads 0x20
    cpu_MemWrite = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h40;
    host_req(1'b0, 8'h20, 8'h00);
    tick();
    host_valid = 1'b0;
    for (int i = 1; i < 20; i++) begin
      cpu_wdata = 8'(8'h40 + i);
      #1;
      chk($sformatf("blk_ramdata_%0d", i), 32'(ram_wdata), 32'(8'h40 + i));
      chk($sformatf("blk_done_%0d", i), 32'(host_done), 32'd0);
      chk($sformatf("blk_starve_%0d", i), 32'(starve), 32'((i - 1) >= 15));
      tick();
    end
    cpu_MemWrite = 1'b0;
    #1;
    chk("blk_host_re",  32'(ram_MemRead), 32'd1);
    chk("blk_starve_hi", 32'(starve), 32'd1);
    tick();
    chk("blk_done",  32'(host_done), 32'd1);
    chk("blk_rdata", 32'(host_rdata), 32'h53);
    chk("blk_starve_lo", 32'(starve), 32'd0);
    tick();
    chk("blk_xfers", 32'(host_xfers), 32'd3);

    // Same-cycle CPU load and host write of 0x30
    cpu_MemRead = 1'b1; cpu_addr = 8'h30;
    host_req(1'b1, 8'h30, 8'h77);
    #1;
    chk("same_cpu_old", 32'(cpu_rdata), 32'h11);
    tick();
    cpu_MemRead = 1'b0; host_valid = 1'b0;
    #1;
    chk("same_ram_we",   32'(ram_MemWrite), 32'd1);
    chk("same_ram_data", 32'(ram_wdata), 32'h77);
    tick();
    cpu_MemRead = 1'b1; cpu_addr = 8'h30;
    #1;
    chk("same_cpu_new", 32'(cpu_rdata), 32'h77);
    tick();
    cpu_MemRead = 1'b0;
    chk("same_xfers", 32'(host_xfers), 32'd4);

    // Four back-to-back writes with host_valid held high
    for (int i = 0; i < 4; i++) begin
      host_req(1'b1, 8'(8'h40 + i), 8'(8'hC0 + i));
      chk($sformatf("b2b_ready_acc_%0d", i), 32'(host_ready), 32'd1);
      tick();
      chk($sformatf("b2b_pend_ready_%0d", i), 32'(host_ready), 32'd0);
      chk($sformatf("b2b_pend_done_%0d", i), 32'(host_done), 32'd0);
      tick();
      chk($sformatf("b2b_done_%0d", i), 32'(host_done), 32'd1);
      chk($sformatf("b2b_mem_%0d", i), 32'(mem[8'h40 + i]), 32'(8'hC0 + i));
    end
    host_valid = 1'b0;
    tick();
    chk("b2b_xfers", 32'(host_xfers), 32'd8);

    // Reset while a host write to 0x50 is stuck behind CPU stores to 0x51
    cpu_MemWrite = 1'b1; cpu_addr = 8'h51; cpu_wdata = 8'h01;
    host_req(1'b1, 8'h50, 8'hEE);
    tick();
    host_valid = 1'b0;
    chk("rstp_pend", 32'(dbg_state), 32'd1);
    cpu_MemWrite = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("rstp");
    tick();
    chk("rstp_mem", 32'(mem[8'h50]), 32'h99);
    reset = 1'b0;
    tick();

    // Twenty transfers; 4-bit counter must stick at 15
    exp_x = 0;
    for (int i = 0; i < 20; i++) begin
      host_req(i[0], 8'(8'h60 + i), 8'(i));
      tick();
      host_valid = 1'b0;
      tick();
      chk($sformatf("sat_done_%0d", i), 32'(host_done), 32'd1);
      chk($sformatf("sat_cnt_%0d", i), 32'(host_xfers), 32'(exp_x));
      if (exp_x < 15) exp_x++;
    end
    tick();
    chk("sat_final", 32'(host_xfers), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the 256-byte data RAM between the pipeline MEM stage and an external host/debug port used for program data loading and inspection. It sits between the EX/MEM outputs (address, store data, MemRead/MemWrite) and the RAM instance. The CPU always has priority. Host accesses are accepted through a valid/ready handshake and complete in idle RAM cycles. A wait counter flags host starvation for a future stall hook into hazard detection.

## Interface
Parameters:
- MAX_WAIT, 15: host-blocked cycles before `starve` asserts (1..255)
- XFER_W, 16: width of the completed-host-transfer counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  8  MEM-stage address (ALU result)
- cpu_wdata  in  8  MEM-stage store data
- cpu_MemRead  in  1  MEM-stage load
- cpu_MemWrite  in  1  MEM-stage store
- cpu_rdata  out  8  load data to MEM/WB, combinational from ram_rdata
- host_valid  in  1  host request valid
- host_we  in  1  1 = write, 0 = read
- host_addr  in  8  host address
- host_wdata  in  8  host write data
- host_ready  out  1  arbiter can accept a request this cycle
- host_done  out  1  one-cycle completion pulse
- host_rdata  out  8  registered read data, valid while host_done=1 and held until the next completion
- ram_addr  out  8  to RAM addr
- ram_wdata  out  8  to RAM wdata
- ram_MemRead  out  1  to RAM MemRead
- ram_MemWrite  out  1  to RAM MemWrite (RAM write commits on clk edge)
- ram_rdata  in  8  RAM combinational read data
- starve  out  1  host has waited ≥ MAX_WAIT blocked cycles
- host_xfers  out  XFER_W  saturating count of completed host transfers

## Operation
- The CPU is busy (`cpu_busy`) when cpu_MemRead | cpu_MemWrite. When busy, the RAM ports pass the CPU signals through unchanged.
- FSM states:
  - IDLE: on host_valid & host_ready, capture we, addr and wdata into holding registers, then go to PEND.
  - PEND:
    - If !cpu_busy: drive the RAM with the held request (ram_MemWrite = we, ram_MemRead = !we). At the edge, capture ram_rdata into host_rdata (reads only) and go to DONE.
    - If cpu_busy: stay in PEND and increment wait_cnt.
  - DONE: host_done = 1 and host_xfers increments. If a new request is accepted this cycle, go to PEND; otherwise go to IDLE.
- host_ready = (state == IDLE) | (state == DONE). A transfer is accepted only on a cycle with valid & ready. Host fields are sampled only on that cycle.
- In IDLE and DONE with the CPU not busy, the RAM outputs are all zero (no access).
- wait_cnt:
  - Width is enough for MAX_WAIT, saturating at MAX_WAIT.
  - Cleared on every accept.
  - starve = (state == PEND) & (wait_cnt >= MAX_WAIT).
- The host write-data register is ignored for reads. host_rdata is left unchanged by writes.
- host_xfers saturates at all-ones and never wraps.

## Timing
- Reset values: state = IDLE, host_rdata = 0, host_done = 0, host_xfers = 0, wait_cnt = 0, starve = 0, host_ready = 1.
- Asserting reset mid-PEND drops the held request immediately; ram_MemWrite from the host path falls combinationally and no write is issued.
- The CPU path is combinational and adds zero cycles; CPU load data arrives in the same cycle as today.
- Unblocked host latency: accept at edge N, RAM access during cycle N+1, host_done high in cycle N+2.
- Back-to-back throughput: one transfer per 2 cycles.
- Each blocked cycle adds exactly 1 cycle of latency. There is no timeout or abort; the host waits indefinitely.
- If the CPU and host are both requesting, the CPU wins every cycle. The host accesses on the first cycle the CPU is idle.
- A host write followed by a CPU read of the same address in a later cycle returns the new data. There is no write buffering.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum {IDLE, PEND, DONE}
  - DMEM_ADDR_W = 8, DMEM_DATA_W = 8
- One sub-module is natural: `sat_counter` (parameterised width, inc, clr, saturating), used for both wait_cnt and host_xfers.
- The RAM output mux stays inline.

## Test plan
- Idle CPU, host write addr 0x10 = 0xA5, then host read 0x10 -> host_done two cycles after each accept; host_rdata = 0xA5; host_xfers = 2.
- CPU store at 0x20 every cycle for 20 cycles while the host reads 0x20 -> host stays in PEND; starve rises when wait_cnt reaches 15; the host completes on the first CPU-idle cycle with the CPU's last written value.
- Same-cycle CPU load 0x30 and host write 0x30 = 0x77 -> the CPU load sees the old data with no added latency; the host write commits on the next idle cycle; a following CPU load returns 0x77.
- Host valid held continuously with 4 queued writes on an idle CPU -> accepts at cycles 0, 2, 4, 6; host_done at 2, 4, 6, 8; host_ready never falls in DONE.
- Assert reset while in PEND with a host write pending -> ram_MemWrite = 0 immediately, the RAM location is unchanged, all outputs return to reset values, host_ready = 1.
- Force host_xfers to near-max using XFER_W = 4 and run 20 transfers -> the count holds at 15 and does not wrap.
